// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer.
// FSM state encoding, recode operations and the default operand width.
package booth_pkg;

    localparam int unsigned BOOTH_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } op_e;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}.
    function automatic op_e recode_op(input logic q0, input logic q_1);
        unique case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Booth recoder: turns the multiplier bit pair into the adder's b operand and carry-in.
// Subtraction is formed as ~M + 1 through the adder carry-in.
module booth_recode
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH
) (
    input  logic             en,
    input  logic             q0,
    input  logic             q_1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin
);

    op_e op;

    assign op = en ? recode_op(q0, q_1) : OP_NOP;

    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        unique case (op)
            OP_ADD: add_b = m;
            OP_SUB: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/booth_radix2_sequencer.sv
// Sequential radix-2 Booth multiplier: holds A/Q/M/q_1, drives an external adder each cycle
// and performs one add/subtract-and-arithmetic-shift iteration per RUN cycle.
module booth_radix2_sequencer
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               q1_q, q1_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sum_sign;

    booth_recode #(
        .WIDTH (WIDTH)
    ) u_recode (
        .en      (state_q == RUN),
        .q0      (q_q[0]),
        .q_1     (q1_q),
        .m       (m_q),
        .add_b   (add_b),
        .add_cin (add_cin)
    );

    assign add_a     = a_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = {a_q, q_q};

    // Sign of the WIDTH+1-bit sum; add_sum[WIDTH-1] alone is wrong when M = -2^(WIDTH-1).
    assign sum_sign = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    m_d     = multiplicand;
                    q1_d    = 1'b0;
                    count_d = CNT_W'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = {sum_sign, add_sum[WIDTH-1:1]};
                q_d     = {add_sum[0], q_q[WIDTH-1:1]};
                q1_d    = q_q[0];
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            count_q <= count_d;
        end
    end

endmodule
